// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle for mips_mem_arbiter: two requester ports (cpu, ext), one memory port and a state debug tap.
// Handshake: a requester holds req until it sees gnt (1-cycle pulse, combinational in the accept cycle);
// from gnt on, its signals are ignored until done pulses; reads deliver rdata while done=1.
interface mips_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_done;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        dbg_state;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_done, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  dbg_state
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_done, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output dbg_state
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Two-port (cpu/ext) single-outstanding memory arbiter with fixed read latency MEM_LAT.
// Define MIPS_ARB_CPU_PRIO_EN for fixed CPU priority on ties; otherwise ties alternate (round-robin).
module mips_mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  mips_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_EXT  = 1'b1;
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic any_req;
  logic pick_ext;

  always_comb begin
    any_req = bus.cpu_req | bus.ext_req;
`ifdef MIPS_ARB_CPU_PRIO_EN
    pick_ext = bus.ext_req & ~bus.cpu_req;
`else
    // On a tie the port that did not win last time goes next.
    pick_ext = bus.ext_req & (~bus.cpu_req | (last_owner_q == OWN_CPU));
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d      = pick_ext;
          last_owner_d = pick_ext;
          we_d         = pick_ext ? bus.ext_we    : bus.cpu_we;
          addr_d       = pick_ext ? bus.ext_addr  : bus.cpu_addr;
          wdata_d      = pick_ext ? bus.ext_wdata : bus.cpu_wdata;
          state_d      = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        cnt_d   = 4'd0;
        state_d = we_q ? ARB_DONE : ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          if (owner_q == OWN_EXT) ext_rdata_d = bus.mem_rdata;
          else                    cpu_rdata_d = bus.mem_rdata;
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_EXT;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  // Grants are combinational from the request, so they are gated by rst explicitly.
  assign bus.cpu_gnt   = ~rst & (state_q == ARB_IDLE) & bus.cpu_req & ~pick_ext;
  assign bus.ext_gnt   = ~rst & (state_q == ARB_IDLE) & pick_ext;
  assign bus.cpu_done  = (state_q == ARB_DONE) & (owner_q == OWN_CPU);
  assign bus.ext_done  = (state_q == ARB_DONE) & (owner_q == OWN_EXT);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ext_rdata = ext_rdata_q;

  assign bus.mem_en    = (state_q == ARB_ACCESS);
  assign bus.mem_we    = (state_q == ARB_ACCESS) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, default 32, memory data width.
- ADDR_W, default 32, memory address width.
- MEM_LAT, default 1, legal range 1..15, cycles from the mem_en cycle to mem_rdata being valid.

REQ-002 SHALL have ports, one per line:
- clk in 1: sole clock, rising edge.
- rst in 1: reset, asynchronous, active-high.
- cpu_req in 1: CPU access request.
- cpu_we in 1: CPU write (1) / read (0).
- cpu_addr in ADDR_W: CPU address.
- cpu_wdata in DATA_W: CPU write data.
- cpu_gnt out 1: CPU request accepted, 1-cycle pulse.
- cpu_done out 1: CPU access complete, 1-cycle pulse.
- cpu_rdata out DATA_W: CPU read data, valid while cpu_done=1 for reads.
- ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_done, ext_rdata: external loader/debug port, same directions, widths and meanings as the cpu_* ports.
- mem_en out 1: memory access strobe.
- mem_we out 1: memory write enable.
- mem_addr out ADDR_W: memory address.
- mem_wdata out DATA_W: memory write data.
- mem_rdata in DATA_W: memory read data.

Function
REQ-003 SHALL implement FSM states ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_DONE.
REQ-004 In ARB_IDLE with any req=1 in cycle T:
- SHALL select one owner and pulse that owner's gnt combinationally in T.
- SHALL capture the owner's we/addr/wdata.
- SHALL move to ARB_ACCESS.
With no request, SHALL stay in ARB_IDLE.
REQ-005 ARB_ACCESS (T+1):
- SHALL drive mem_en=1, with mem_we/mem_addr/mem_wdata from the captured values.
- Write: SHALL go to ARB_DONE.
- Read: SHALL go to ARB_WAIT.
REQ-006 ARB_WAIT:
- SHALL drive mem_en=0.
- SHALL count MEM_LAT cycles using a 4-bit counter.
- In the final WAIT cycle SHALL capture mem_rdata into the owner's rdata register, then go to ARB_DONE.
REQ-007 ARB_DONE:
- SHALL pulse the owner's done for exactly one cycle.
- SHALL return to ARB_IDLE.
- Read done SHALL occur at T+2+MEM_LAT; write done at T+2.
REQ-008 Requests SHALL be accepted only in ARB_IDLE. Minimum spacing between successive grants SHALL be 3 cycles for writes and 3+MEM_LAT cycles for reads.
REQ-009 Requester signals after gnt SHALL be ignored until that requester's done. A req dropped before gnt SHALL be a legal withdrawal and SHALL cause no access.
REQ-010 Simultaneous cpu_req and ext_req in ARB_IDLE SHALL be resolved per REQ-016. A single requester SHALL always be granted.
REQ-011 A last_owner register SHALL update on every grant and SHALL reset to EXT, so that CPU wins the first tie.
REQ-012 The non-owner's gnt and done SHALL remain 0 throughout a transaction. Each rdata register SHALL hold its value until that port's next read completes.
REQ-013 mem_en SHALL be 1 only in ARB_ACCESS. mem_we SHALL be 0 whenever mem_en=0.

Reset
REQ-014 rst=1 SHALL, without waiting for a clock edge:
- force ARB_IDLE;
- clear the counter;
- set last_owner=EXT;
- drive all gnt, done, mem_en and mem_we to 0;
- set rdata registers and captured addr/wdata to 0.
REQ-015 Reset asserted mid-access SHALL abort the transaction with no done pulse. The first request after rst deasserts SHALL be handled as from a fresh ARB_IDLE.

Configuration
REQ-016 Macro MIPS_ARB_CPU_PRIO_EN:
- Defined: a tie SHALL always grant CPU (fixed priority; ext may starve).
- Undefined: a tie SHALL grant the requester that is not last_owner (round-robin).
- last_owner SHALL be maintained in both builds.

Verification
REQ-017 A bench SHALL cover these directed scenarios:
- CPU read: MEM_LAT=1, cpu_req/we=0/addr=0x10 at T, mem_rdata=0xDEADBEEF -> cpu_gnt at T, mem_en at T+1, cpu_done with cpu_rdata=0xDEADBEEF at T+3.
- Ext write: ext_req/we=1/addr=0x40/wdata=0x12345678 -> mem_en=mem_we=1, mem_addr=0x40, mem_wdata=0x12345678 at T+1, ext_done at T+2, cpu_* outputs idle.
- Round-robin ties (macro undefined): both reqs held across 4 transactions -> grant order CPU, EXT, CPU, EXT.
- Fixed priority (MIPS_ARB_CPU_PRIO_EN defined): both reqs held -> CPU granted every transaction, ext_gnt never asserted.
- Reset mid-access: MEM_LAT=3, rst=1 during ARB_WAIT -> mem_en=0, no done pulse; next cpu_req granted in its first cycle after rst deasserts.
- Request ignored when busy: cpu_wdata changed and cpu_req dropped after gnt -> captured wdata written; ext_req arriving mid-transaction is granted only in the cycle after ARB_DONE.
